// File: rtl/projectile_sequencer.sv
// projectile_sequencer: per-player fireball launch, flight termination, cooldown and scoring
module projectile_player #(
  parameter int COOLDOWN_FRAMES = 30,
  parameter int X_MIN_LIMIT     = 5,
  parameter int X_MAX_LIMIT     = 630,
  parameter int MAX_FLIGHT      = 160
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       startscreen,
  input  logic       shoot,
  input  logic       flip,
  input  logic       collision,
  input  logic [9:0] ball_x,
  output logic       flying,
  output logic       flip_lat,
  output logic       hit,
  output logic [3:0] score,
  output logic       ready
);
  localparam int FCW = $clog2(MAX_FLIGHT + 1);
  localparam int CDW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(MAX_FLIGHT - 1);
  localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_FRAMES - 1);
  localparam logic [9:0] X_MIN = 10'(X_MIN_LIMIT);
  localparam logic [9:0] X_MAX = 10'(X_MAX_LIMIT);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  state_t         state, next_state;
  logic           shoot_q;
  logic [FCW-1:0] fc, fc_next;
  logic [CDW-1:0] cd, cd_next;
  logic           hit_next, flip_next;
  logic [3:0]     score_next;
  logic           fire, out_of_bounds;

  // a key held across reset or a flight must be released before it can fire again
  assign fire          = shoot & ~shoot_q;
  // unsigned compare also catches a leftward wrap below zero as a large x
  assign out_of_bounds = (ball_x < X_MIN) | (ball_x > X_MAX);

  // next state plus counter, hit and score updates; startscreen overrides everything
  always_comb begin
    next_state = state;
    fc_next    = fc;
    cd_next    = cd;
    hit_next   = 1'b0;
    flip_next  = flip_lat;
    score_next = score;
    if (startscreen) begin
      next_state = IDLE;
      fc_next    = '0;
      cd_next    = '0;
      score_next = '0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          next_state = FLYING;
          fc_next    = '0;
          flip_next  = flip;
        end
        FLYING: if (collision) begin
          next_state = COOLDOWN;
          cd_next    = CD_LOAD;
          hit_next   = 1'b1;
          score_next = (score == 4'hf) ? score : score + 4'd1;
        end else if (out_of_bounds || fc == FC_LAST) begin
          next_state = COOLDOWN;
          cd_next    = CD_LOAD;
        end else begin
          fc_next = fc + 1'b1;
        end
        COOLDOWN: if (cd == '0) next_state = IDLE;
                  else cd_next = cd - 1'b1;
        default: next_state = IDLE;
      endcase
    end
  end

  // state and registered outputs; async reset drops a flight without a hit pulse
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      shoot_q  <= 1'b1;
      fc       <= '0;
      cd       <= '0;
      flying   <= 1'b0;
      flip_lat <= 1'b0;
      hit      <= 1'b0;
      score    <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= next_state;
      shoot_q  <= shoot;
      fc       <= fc_next;
      cd       <= cd_next;
      flying   <= next_state == FLYING;
      flip_lat <= flip_next;
      hit      <= hit_next;
      score    <= score_next;
      ready    <= (next_state == IDLE) & ~startscreen;
    end
  end
endmodule

module projectile_sequencer #(
  parameter int COOLDOWN_FRAMES = 30,
  parameter int X_MIN_LIMIT     = 5,
  parameter int X_MAX_LIMIT     = 630,
  parameter int MAX_FLIGHT      = 160
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       startscreen,
  input  logic       shoot,
  input  logic       shoot2,
  input  logic       flip,
  input  logic       ballcollision,
  input  logic       ballcollision2,
  input  logic [9:0] BallX,
  input  logic [9:0] BallX2,
  output logic       flying,
  output logic       flying2,
  output logic [1:0] flip_lat,
  output logic       hit1,
  output logic       hit2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       ready1,
  output logic       ready2
);
  projectile_player #(
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES), .X_MIN_LIMIT(X_MIN_LIMIT),
    .X_MAX_LIMIT(X_MAX_LIMIT), .MAX_FLIGHT(MAX_FLIGHT)
  ) p1 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .startscreen(startscreen),
    .shoot(shoot), .flip(flip), .collision(ballcollision), .ball_x(BallX),
    .flying(flying), .flip_lat(flip_lat[0]), .hit(hit1), .score(score1), .ready(ready1)
  );

  projectile_player #(
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES), .X_MIN_LIMIT(X_MIN_LIMIT),
    .X_MAX_LIMIT(X_MAX_LIMIT), .MAX_FLIGHT(MAX_FLIGHT)
  ) p2 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .startscreen(startscreen),
    .shoot(shoot2), .flip(flip), .collision(ballcollision2), .ball_x(BallX2),
    .flying(flying2), .flip_lat(flip_lat[1]), .hit(hit2), .score(score2), .ready(ready2)
  );
endmodule

// File: tb/tb_projectile_sequencer.sv
// tb_projectile_sequencer: table vectors plus directed multi-frame sequences
module tb_projectile_sequencer;
  logic       frame_clk, Reset_n, startscreen, shoot, shoot2, flip;
  logic       ballcollision, ballcollision2;
  logic [9:0] BallX, BallX2;
  logic       flying, flying2, hit1, hit2, ready1, ready2;
  logic [1:0] flip_lat;
  logic [3:0] score1, score2;
  int         checks = 0;
  int         errors = 0;

  projectile_sequencer dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .startscreen(startscreen),
    .shoot(shoot), .shoot2(shoot2), .flip(flip),
    .ballcollision(ballcollision), .ballcollision2(ballcollision2),
    .BallX(BallX), .BallX2(BallX2), .flying(flying), .flying2(flying2),
    .flip_lat(flip_lat), .hit1(hit1), .hit2(hit2), .score1(score1), .score2(score2),
    .ready1(ready1), .ready2(ready2)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [5:0] in;
    logic [3:0] flags;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] rdy;
    logic [1:0] fll;
  } vec_t;

  vec_t vecs [7];

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic launch1(input logic [9:0] x);
    BallX = x;
    shoot = 1'b1;
    tick;
    shoot = 1'b0;
    chk("launch_flying", int'(flying), 1);
    chk("launch_ready", int'(ready1), 0);
  endtask

  task automatic wait_ready1(input int exp_n);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (!ready1 && n < 100);
    chk("cooldown_len", n, exp_n);
  endtask

  initial begin
    int n;
    Reset_n = 1'b0; startscreen = 1'b0; shoot = 1'b0; shoot2 = 1'b0; flip = 1'b0;
    ballcollision = 1'b0; ballcollision2 = 1'b0; BallX = 10'd320; BallX2 = 10'd320;
    // {ss,sh,sh2,flip,c1,c2} -> {fly,fly2,hit1,hit2}, score1, score2, {rdy1,rdy2}, flip_lat
    vecs[0] = {6'b000000, 4'b0000, 4'd0, 4'd0, 2'b11, 2'b00};
    vecs[1] = {6'b011100, 4'b1100, 4'd0, 4'd0, 2'b00, 2'b11};
    vecs[2] = {6'b011000, 4'b1100, 4'd0, 4'd0, 2'b00, 2'b11};
    vecs[3] = {6'b000011, 4'b0011, 4'd1, 4'd1, 2'b00, 2'b11};
    vecs[4] = {6'b000011, 4'b0000, 4'd1, 4'd1, 2'b00, 2'b11};
    vecs[5] = {6'b011000, 4'b0000, 4'd1, 4'd1, 2'b00, 2'b11};
    vecs[6] = {6'b000000, 4'b0000, 4'd1, 4'd1, 2'b00, 2'b11};
    #22;
    chk("reset_flags", int'({flying, flying2, hit1, hit2, ready1, ready2}), 0);
    chk("reset_scores", int'({score1, score2, flip_lat}), 0);
    Reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      {startscreen, shoot, shoot2, flip, ballcollision, ballcollision2} = vecs[i].in;
      tick;
      chk($sformatf("vec%0d_flags", i), int'({flying, flying2, hit1, hit2}), int'(vecs[i].flags));
      chk($sformatf("vec%0d_score1", i), int'(score1), int'(vecs[i].s1));
      chk($sformatf("vec%0d_score2", i), int'(score2), int'(vecs[i].s2));
      chk($sformatf("vec%0d_ready", i), int'({ready1, ready2}), int'(vecs[i].rdy));
      chk($sformatf("vec%0d_flip_lat", i), int'(flip_lat), int'(vecs[i].fll));
    end
    for (int k = 4; k <= 30; k++) begin
      tick;
      if (k == 29) chk("ready_early", int'({ready1, ready2}), 0);
      if (k == 30) chk("ready_on_time", int'({ready1, ready2}), 3);
    end
    // collision and out-of-bounds together count as a hit
    launch1(10'd320);
    BallX = 10'd700; ballcollision = 1'b1;
    tick;
    ballcollision = 1'b0; BallX = 10'd320;
    chk("coll_oob_hit", int'(hit1), 1);
    chk("coll_oob_flying", int'(flying), 0);
    chk("coll_oob_score", int'(score1), 2);
    tick;
    chk("hit_one_frame", int'(hit1), 0);
    wait_ready1(29);
    // rightward ramp ends as a miss just past the limit
    launch1(10'd300);
    for (int x = 305; x <= 630; x += 5) begin
      BallX = 10'(x);
      tick;
      chk("ramp_flying", int'(flying), 1);
    end
    BallX = 10'd631;
    tick;
    chk("ramp_end_flying", int'(flying), 0);
    chk("ramp_no_hit", int'(hit1), 0);
    chk("ramp_score", int'(score1), 2);
    BallX = 10'd320;
    wait_ready1(30);
    // leftward wrap and low limit
    launch1(10'd320);
    BallX = 10'd5;
    tick;
    chk("xmin_edge_flying", int'(flying), 1);
    BallX = 10'd1021;
    tick;
    chk("wrap_flying", int'(flying), 0);
    wait_ready1(30);
    launch1(10'd320);
    BallX = 10'd4;
    tick;
    chk("below_min_flying", int'(flying), 0);
    wait_ready1(30);
    // launch already past the right limit lasts one frame
    launch1(10'd700);
    tick;
    chk("late_launch_end", int'(flying), 0);
    BallX = 10'd320;
    wait_ready1(30);
    // held key, and a press during cooldown, never relaunch
    shoot = 1'b1;
    tick;
    chk("hold_launch", int'(flying), 1);
    BallX = 10'd700;
    tick;
    chk("hold_end", int'(flying), 0);
    BallX = 10'd320;
    for (int k = 1; k <= 30; k++) begin
      shoot = (k < 5 || k >= 10);
      tick;
      if (k == 10) chk("cd_press_dropped", int'(flying), 0);
      if (k == 29) chk("hold_ready_early", int'(ready1), 0);
    end
    chk("hold_ready", int'(ready1), 1);
    tick;
    tick;
    chk("hold_no_relaunch", int'(flying), 0);
    shoot = 1'b0;
    tick;
    shoot = 1'b1;
    tick;
    chk("repress_launch", int'(flying), 1);
    shoot = 1'b0; BallX = 10'd700;
    tick;
    BallX = 10'd320;
    wait_ready1(30);
    // timeout after a full flight
    launch1(10'd320);
    n = 0;
    do begin
      tick;
      n++;
    end while (flying && n < 200);
    chk("flight_len", n, 160);
    chk("timeout_no_hit", int'(hit1), 0);
    wait_ready1(30);
    // startscreen mid-flight clears everything and blocks firing
    launch1(10'd320);
    tick;
    startscreen = 1'b1;
    tick;
    chk("ss_flying", int'(flying), 0);
    chk("ss_scores", int'({score1, score2}), 0);
    chk("ss_ready", int'({ready1, ready2}), 0);
    shoot = 1'b1;
    tick;
    chk("ss_fire_ignored", int'(flying), 0);
    startscreen = 1'b0;
    tick;
    chk("ss_release_flying", int'(flying), 0);
    chk("ss_release_ready", int'(ready1), 1);
    shoot = 1'b0;
    tick;
    // score saturates at 15
    for (int i = 1; i <= 16; i++) begin
      shoot = 1'b1;
      tick;
      shoot = 1'b0; ballcollision = 1'b1;
      tick;
      ballcollision = 1'b0;
      if (i == 15) chk("score_15", int'(score1), 15);
      if (i == 16) begin
        chk("score_sat", int'(score1), 15);
        chk("sat_hit", int'(hit1), 1);
      end
      wait_ready1(30);
    end
    // async reset mid-flight
    launch1(10'd320);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_flying", int'(flying), 0);
    chk("async_reset_score", int'(score1), 0);
    chk("async_reset_hit", int'(hit1), 0);
    shoot = 1'b1;
    tick;
    Reset_n = 1'b1;
    tick;
    chk("held_through_reset", int'(flying), 0);
    chk("post_reset_ready", int'(ready1), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end
endmodule
